// File: rtl/axis_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_step_ctrl
// Brief    : Multi-axis step-command controller (absolute target -> dir/pulses)
// Revision : 1.0
// ============================================================================
module axis_step_ctrl #(
    parameter int N_AXES      = 6,
    parameter int AXIS_W      = 3,
    parameter int POS_W       = 10,
    parameter int PULSE_W     = 16,
    parameter int SCALE_SHIFT = 2,
    parameter int IDLE_CYCLES = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_AXES-1:0]           init_done,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [AXIS_W-1:0]           cmd_axis,
    input  logic [POS_W-1:0]            cmd_pos,
    input  logic [N_AXES-1:0]           busy,
    output logic [N_AXES*PULSE_W-1:0]   pulse_num,
    output logic [N_AXES-1:0]           dir,
    output logic [N_AXES-1:0]           start,
    output logic [N_AXES-1:0]           en,
    output logic                        cmd_err
);

    localparam int c_SHIFT_W = POS_W + SCALE_SHIFT;
    localparam int c_CNT_W   = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_IDLE_LAST =
        c_CNT_W'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);

    logic [POS_W-1:0]   r_last_pos   [N_AXES];
    logic [PULSE_W-1:0] r_pend_steps [N_AXES];
    logic [PULSE_W-1:0] r_pulse      [N_AXES];
    logic [c_CNT_W-1:0] r_idle_cnt   [N_AXES];
    logic [N_AXES-1:0]  r_pend;
    logic [N_AXES-1:0]  r_pend_dir;

    logic [N_AXES-1:0]  w_sel;
    logic [N_AXES-1:0]  w_dispatch;
    logic [N_AXES-1:0]  w_idle;
    logic               w_axis_ok;
    logic               w_homed;
    logic               w_pend_sel;
    logic               w_accept;
    logic               w_good;
    logic               w_bad;
    logic               w_dir_new;
    logic [POS_W-1:0]   w_last_sel;
    logic [POS_W-1:0]   w_delta;
    logic [c_SHIFT_W-1:0] w_shifted;
    logic [PULSE_W-1:0] w_steps;

    // Out-of-range axis indices match no entry, so they never read past the arrays
    always_comb begin
        w_sel      = '0;
        w_homed    = 1'b0;
        w_pend_sel = 1'b0;
        w_last_sel = '0;
        for (int i = 0; i < N_AXES; i++) begin
            if (cmd_axis == AXIS_W'(i)) begin
                w_sel[i]   = 1'b1;
                w_homed    = init_done[i];
                w_pend_sel = r_pend[i];
                w_last_sel = r_last_pos[i];
            end
        end
    end

    assign w_axis_ok = |w_sel;
    assign cmd_ready = !w_axis_ok || !w_homed || !w_pend_sel;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_good    = w_accept && w_axis_ok && w_homed;
    assign w_bad     = w_accept && !(w_axis_ok && w_homed);

    assign w_dir_new = cmd_pos > w_last_sel;
    assign w_delta   = w_dir_new ? (cmd_pos - w_last_sel) : (w_last_sel - cmd_pos);
    assign w_shifted = c_SHIFT_W'(w_delta) << SCALE_SHIFT;

    generate
        if (c_SHIFT_W > PULSE_W) begin : g_sat
            assign w_steps = (|w_shifted[c_SHIFT_W-1:PULSE_W]) ? {PULSE_W{1'b1}}
                                                                : w_shifted[PULSE_W-1:0];
        end else begin : g_nosat
            assign w_steps = PULSE_W'(w_shifted);
        end
    endgenerate

    always_comb begin
        w_dispatch = '0;
        w_idle     = '0;
        for (int i = 0; i < N_AXES; i++) begin
            w_dispatch[i] = r_pend[i] && !busy[i] && !start[i] && init_done[i];
            w_idle[i]     = en[i] && !busy[i] && !r_pend[i] && !start[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_AXES; g++) begin : g_pulse_out
            assign pulse_num[g*PULSE_W +: PULSE_W] = r_pulse[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_err    <= 1'b0;
            start      <= '0;
            en         <= '0;
            dir        <= '0;
            r_pend     <= '0;
            r_pend_dir <= '0;
            for (int i = 0; i < N_AXES; i++) begin
                r_last_pos[i]   <= '0;
                r_pend_steps[i] <= '0;
                r_pulse[i]      <= '0;
                r_idle_cnt[i]   <= '0;
            end
        end else begin
            cmd_err <= w_bad;
            for (int i = 0; i < N_AXES; i++) begin
                start[i] <= w_dispatch[i];
                // An unhomed axis forgets its position; an in-flight move keeps running
                if (!init_done[i]) begin
                    r_pend[i]     <= 1'b0;
                    en[i]         <= 1'b0;
                    r_last_pos[i] <= '0;
                    r_idle_cnt[i] <= '0;
                end else begin
                    if (w_dispatch[i]) begin
                        r_pulse[i] <= r_pend_steps[i];
                        dir[i]     <= r_pend_dir[i];
                        en[i]      <= 1'b1;
                        r_pend[i]  <= 1'b0;
                    end else if (w_good && w_sel[i]) begin
                        r_last_pos[i] <= cmd_pos;
                        if (|w_delta) begin
                            r_pend[i]       <= 1'b1;
                            r_pend_dir[i]   <= w_dir_new;
                            r_pend_steps[i] <= w_steps;
                        end
                    end
                    if (w_idle[i]) begin
                        if ((IDLE_CYCLES != 0) && (r_idle_cnt[i] == c_IDLE_LAST)) begin
                            en[i]         <= 1'b0;
                            r_idle_cnt[i] <= '0;
                        end else begin
                            r_idle_cnt[i] <= r_idle_cnt[i] + c_CNT_W'(1);
                        end
                    end else begin
                        r_idle_cnt[i] <= '0;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/axis_step_ctrl.md
Name: axis_step_ctrl

Overview:
- Parametrised multi-axis step-command controller.
- Accepts absolute target positions per axis through a valid/ready command port and converts each one into a direction and a scaled pulse count relative to that axis's last committed target.
- Holds one pending command per axis and dispatches it to that axis's pulse generator when the generator is idle.
- Manages per-axis motor enable, including an idle power-down timeout.

Parameters:
N_AXES, 6, number of motor axes
AXIS_W, 3, width of axis index (>= clog2(N_AXES))
POS_W, 10, width of target position
PULSE_W, 16, width of pulse count per axis
SCALE_SHIFT, 2, pulses per position unit = 2^SCALE_SHIFT
IDLE_CYCLES, 1000, idle cycles before enable drops; 0 = never drop

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active low (asserted when 0)
init_done  in  N_AXES  per-axis homing complete
cmd_valid  in  1  command present
cmd_ready  out  1  command can be taken this cycle
cmd_axis  in  AXIS_W  target axis
cmd_pos  in  POS_W  absolute target position
busy  in  N_AXES  per-axis pulse generator running
pulse_num  out  N_AXES*PULSE_W  per-axis pulse count; axis i occupies [i*PULSE_W +: PULSE_W]
dir  out  N_AXES  per-axis direction; 1 = increasing position
start  out  N_AXES  one-cycle dispatch strobe per axis
en  out  N_AXES  per-axis motor power / generator enable
cmd_err  out  1  one-cycle strobe: command rejected

Behaviour:
- Reset (rst=0, async): pulse_num, dir, start, en, cmd_err = 0; internal last_pos, pending flags and idle counters = 0.
- cmd_ready is combinational: 1 if cmd_axis >= N_AXES, or init_done[cmd_axis]=0, or pending[cmd_axis]=0; otherwise 0.
- A command is accepted when cmd_valid && cmd_ready at a rising edge.
- Accepted with cmd_axis >= N_AXES or init_done[cmd_axis]=0: dropped; cmd_err=1 for the next cycle; no state change.
- Accepted on a valid, homed axis a:
  - delta = |cmd_pos - last_pos[a]|, unsigned, POS_W wide.
  - dir_q[a] = (cmd_pos > last_pos[a]).
  - steps = delta << SCALE_SHIFT; saturates to 2^PULSE_W-1 if it overflows PULSE_W.
  - last_pos[a] = cmd_pos.
  - If delta = 0: no pending entry, no error. Otherwise pending[a]=1 holding dir_q and steps.
- Dispatch, per axis i, evaluated independently each cycle:
  - Condition: pending[i] && !busy[i] && !start[i] && init_done[i].
  - On that edge: pulse_num[i] and dir[i] load from pending; start[i]=1 for exactly one cycle; en[i]=1; pending[i]=0.
  - The !start[i] term blocks back-to-back dispatch. The generator must raise busy within 1 cycle of start.
  - pulse_num[i] and dir[i] hold their values until the next dispatch.
- Latency: accept at edge k gives start high from edge k+1 at the earliest (axis idle). Bypassing the pending slot is not allowed.
- Accept and dispatch on the same axis in the same cycle cannot occur, because ready requires pending=0. Accepts on axis a and dispatches on other axes proceed in parallel.
- Idle power-down, per axis:
  - idle_cnt[i] increments while en[i] && !busy[i] && !pending[i] && !start[i]; otherwise it clears.
  - When idle_cnt[i] reaches IDLE_CYCLES (and IDLE_CYCLES != 0): en[i]=0 and the counter clears.
  - en[i] re-asserts only on the next dispatch.
- init_done[i] falling (re-homing) or low: pending[i]=0, en[i]=0, last_pos[i]=0, idle_cnt[i]=0. A dispatch in progress is not aborted; busy is owned by the generator.
- Multiple axes may assert start in the same cycle.

Test Plan:
- Reset, then init_done=6'h3F. Send axis 0, pos 100 -> accepted; next cycle start[0]=1, dir[0]=1, pulse_num[0]=400, en[0]=1.
- Send axis 0, pos 40 after 100 with busy[0]=1 -> pending held; cmd_ready=0 for a further axis-0 command. Drop busy -> start[0] one cycle later with dir=0, pulse_num=240.
- Axis 7, or axis 2 with init_done[2]=0 -> cmd_ready=1, accepted, cmd_err pulses 1 cycle, no start. Repeat pos 40 on axis 0 -> no start, no error.
- PULSE_W=10, SCALE_SHIFT=2, axis 1 from 0 to 1000 -> pulse_num[1]=1023 (saturated).
- IDLE_CYCLES=5 after a completed move with busy low -> en[0] drops exactly 5 idle cycles after busy falls. A new command re-raises en together with start.
- Assert rst=0 mid-move with pending on axes 0 and 3 -> all outputs 0 immediately (async). After release, the first command on axis 0 computes delta from 0.
